// File: rtl/cmp_pkg.sv
// Shared types for the comparator hysteresis tracker.
//   level_t   : debounced level encoding (INIT, LOW, HIGH)
//   verdict_t : one comparator verdict sample {gt, eq, lt}
//   verdict_ok: true when exactly one verdict bit is set
package cmp_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } level_t;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } verdict_t;

  // The XOR is odd-parity, so it passes one or three set bits.
  // The second term rejects the three-bit case, leaving exactly-one-hot.
  function automatic logic verdict_ok(input verdict_t v);
    return (v.gt ^ v.eq ^ v.lt) && !(v.gt && v.eq && v.lt);
  endfunction

endpackage

// File: rtl/cmp_sat_counter.sv
// Saturating up-counter that holds at its all-ones value.
// Ports:
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle unless already saturated
//   cnt_o : current count
module cmp_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt_o
);

  // The count stops at all-ones and never wraps back to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (inc && (cnt_o != {W{1'b1}})) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/cmp_hysteresis_tracker.sv
// Turns a stream of comparator verdicts into a debounced HIGH/LOW level.
// It produces one-cycle rise/fall pulses, a sticky error flag for malformed
// verdicts, and optional saturating per-verdict statistics.
// Configuration macro: CMP_STATS_EN. When it is defined, the gt/eq/lt
// counters are built. When it is undefined, the counters are not built and
// the count outputs are tied to 0.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid                       : sample gt/eq/lt this cycle
//   gt, eq, lt                     : comparator verdict bits
//   level_o                        : INIT=0, LOW=1, HIGH=2
//   rise_o, fall_o                 : one-cycle level transition pulses
//   err_o                          : sticky malformed-verdict flag
//   gt_cnt_o, eq_cnt_o, lt_cnt_o   : saturating verdict counts
module cmp_hysteresis_tracker
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             gt,
  input  logic             eq,
  input  logic             lt,
  output logic [1:0]       level_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic             err_o,
  output logic [CNT_W-1:0] gt_cnt_o,
  output logic [CNT_W-1:0] eq_cnt_o,
  output logic [CNT_W-1:0] lt_cnt_o
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_DONE = RUN_W'(DEBOUNCE);

  verdict_t         verdict;
  logic             sample_ok;
  logic             sample_bad;
  level_t           level;
  level_t           level_nxt;
  logic [RUN_W-1:0] run;
  logic [RUN_W-1:0] run_nxt;
  logic [RUN_W-1:0] run_inc;
  logic             rise_nxt;
  logic             fall_nxt;
  logic             err_nxt;

  assign verdict    = {gt, eq, lt};
  assign sample_ok  = in_valid && verdict_ok(verdict);
  assign sample_bad = in_valid && !verdict_ok(verdict);
  assign run_inc    = run + 1'b1;

  // State, run counter and all outputs are registered.
  // Reset wins over any sample presented in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      level  <= INIT;
      run    <= '0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      err_o  <= 1'b0;
    end else begin
      level  <= level_nxt;
      run    <= run_nxt;
      rise_o <= rise_nxt;
      fall_o <= fall_nxt;
      err_o  <= err_nxt;
    end
  end

  // Next-state logic. Malformed samples only set the error flag.
  // A verdict that opposes the current level counts toward a switch.
  // A verdict that agrees with the current level restarts the run.
  // An eq verdict leaves the run untouched.
  always_comb begin
    level_nxt = level;
    run_nxt   = run;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    err_nxt   = err_o | sample_bad;
    if (sample_ok) begin
      case (level)
        INIT: begin
          run_nxt = '0;
          if (verdict.gt) begin
            level_nxt = HIGH;
          end else if (verdict.lt) begin
            level_nxt = LOW;
          end
        end
        LOW: begin
          if (verdict.gt) begin
            if (run_inc == RUN_DONE) begin
              level_nxt = HIGH;
              run_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              run_nxt = run_inc;
            end
          end else if (verdict.lt) begin
            run_nxt = '0;
          end
        end
        HIGH: begin
          if (verdict.lt) begin
            if (run_inc == RUN_DONE) begin
              level_nxt = LOW;
              run_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              run_nxt = run_inc;
            end
          end else if (verdict.gt) begin
            run_nxt = '0;
          end
        end
        default: begin
          level_nxt = INIT;
          run_nxt   = '0;
        end
      endcase
    end
  end

  assign level_o = level;

`ifdef CMP_STATS_EN
  cmp_sat_counter #(.W(CNT_W)) u_gt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample_ok && verdict.gt),
    .cnt_o (gt_cnt_o)
  );

  cmp_sat_counter #(.W(CNT_W)) u_eq_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample_ok && verdict.eq),
    .cnt_o (eq_cnt_o)
  );

  cmp_sat_counter #(.W(CNT_W)) u_lt_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (sample_ok && verdict.lt),
    .cnt_o (lt_cnt_o)
  );
`else
  assign gt_cnt_o = '0;
  assign eq_cnt_o = '0;
  assign lt_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cmp_hysteresis_tracker.sv
// Scoreboard bench for cmp_hysteresis_tracker with DEBOUNCE=4 and CNT_W=2.
// The driver pushes a hand-computed expectation for every cycle it drives.
// The monitor pops one expectation after each rising edge and compares it.
module tb_cmp_hysteresis_tracker;

  localparam int DEBOUNCE = 4;
  localparam int CNT_W    = 2;
  localparam int SAT      = (1 << CNT_W) - 1;

  typedef struct {
    int step;
    int level;
    int rise;
    int fall;
    int err;
    int gtc;
    int eqc;
    int ltc;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             gt = 1'b0;
  logic             eq = 1'b0;
  logic             lt = 1'b0;
  logic [1:0]       level_o;
  logic             rise_o;
  logic             fall_o;
  logic             err_o;
  logic [CNT_W-1:0] gt_cnt_o;
  logic [CNT_W-1:0] eq_cnt_o;
  logic [CNT_W-1:0] lt_cnt_o;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  int   stepNo = 0;
  int   expGt = 0;
  int   expEq = 0;
  int   expLt = 0;

  cmp_hysteresis_tracker #(.DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .gt       (gt),
    .eq       (eq),
    .lt       (lt),
    .level_o  (level_o),
    .rise_o   (rise_o),
    .fall_o   (fall_o),
    .err_o    (err_o),
    .gt_cnt_o (gt_cnt_o),
    .eq_cnt_o (eq_cnt_o),
    .lt_cnt_o (lt_cnt_o)
  );

  always #5 clk = ~clk;

  // Compares one field and tallies the result.
  task automatic cmpField(input int step, input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL step %0d %s: got %0d, expected %0d", step, name, act, req);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    cmpField(e.step, "level_o", int'(level_o), e.level);
    cmpField(e.step, "rise_o", int'(rise_o), e.rise);
    cmpField(e.step, "fall_o", int'(fall_o), e.fall);
    cmpField(e.step, "err_o", int'(err_o), e.err);
    cmpField(e.step, "gt_cnt_o", int'(gt_cnt_o), e.gtc);
    cmpField(e.step, "eq_cnt_o", int'(eq_cnt_o), e.eqc);
    cmpField(e.step, "lt_cnt_o", int'(lt_cnt_o), e.ltc);
  endtask

  // Expected statistics follow from the inputs alone: a well-formed sample
  // adds one and the count stays at SAT. Without stats everything stays 0.
  task automatic bumpCounts(input logic r, input logic v, input logic g,
                            input logic e, input logic l);
    if (r) begin
      expGt = 0;
      expEq = 0;
      expLt = 0;
    end else if (v && (int'(g) + int'(e) + int'(l) == 1)) begin
`ifdef CMP_STATS_EN
      if (g && expGt < SAT) expGt++;
      if (e && expEq < SAT) expEq++;
      if (l && expLt < SAT) expLt++;
`endif
    end
  endtask

  // Drives one cycle of inputs and queues the expected outputs
  // that should appear after the next rising edge.
  task automatic applyStimulus(input logic r, input logic v, input logic g,
                               input logic e, input logic l,
                               input int expLevel, input int expRise,
                               input int expFall, input int expErr);
    exp_t x;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    gt       = g;
    eq       = e;
    lt       = l;
    bumpCounts(r, v, g, e, l);
    stepNo++;
    x.step  = stepNo;
    x.level = expLevel;
    x.rise  = expRise;
    x.fall  = expFall;
    x.err   = expErr;
    x.gtc   = expGt;
    x.eqc   = expEq;
    x.ltc   = expLt;
    expQ.push_back(x);
  endtask

  // Monitor: outputs are stable 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (expQ.size() > 0) begin
      checkOutput(expQ.pop_front());
    end
  end

  initial begin
    // Reset, then three idle cycles.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // An eq verdict in INIT stays in INIT.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0);
    // Debounce up: lt, then gt, gt, eq, gt, gt.
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2, 0, 0, 0);
    // Interrupted run: lt x3, gt, lt x3 never reaches 4.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 2, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 2, 0, 0, 0);
    // Four more lt: the first completes the run and falls once.
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0);
    // Malformed verdicts set err_o and change nothing else.
    applyStimulus(0, 1, 1, 0, 1, 1, 0, 0, 1);
    applyStimulus(0, 1, 0, 0, 0, 1, 0, 0, 1);
    applyStimulus(0, 1, 1, 1, 1, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 1);
    // Five eq samples saturate eq_cnt_o, and the level holds LOW.
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 1, 0, 1, 0, 0, 1);
    // Reset mid-run: LOW, then gt x3, then reset with a gt sample present.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // After reset the run restarts from zero and needs 4 gt to rise.
    applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 2, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 2, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmp_hysteresis_tracker.md
# cmp_hysteresis_tracker

Downstream consumer of the 8-bit magnitude comparator stage: takes its per-sample `gt`/`eq`/`lt` verdict, qualified by a valid strobe, and turns the raw verdict stream into a debounced HIGH/LOW level with one-cycle rise/fall event pulses. It also keeps saturating per-verdict statistics and flags malformed verdicts. It sits between the combinational comparator and any control logic that must not react to single-sample glitches.

## Interface
- `DEBOUNCE`, default 4: consecutive qualifying samples needed to change level; legal range 1..255.
- `CNT_W`, default 16: width of each statistics counter; legal range 2..32.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: the verdict on `gt`/`eq`/`lt` is sampled this cycle.
- `gt` in 1: comparator verdict A > B.
- `eq` in 1: comparator verdict A == B.
- `lt` in 1: comparator verdict A < B.
- `level_o` out 2: current state encoding, INIT=0, LOW=1, HIGH=2.
- `rise_o` out 1: one-cycle pulse on a LOW→HIGH transition.
- `fall_o` out 1: one-cycle pulse on a HIGH→LOW transition.
- `err_o` out 1: sticky flag; a malformed verdict was seen.
- `gt_cnt_o`, `eq_cnt_o`, `lt_cnt_o` out CNT_W each: saturating verdict counts.

## Operation
- **Well-formed sample:** `in_valid`=1 and exactly one of `gt`/`eq`/`lt` high.
- **Malformed sample:** `in_valid`=1 and zero, or two or more, verdict bits high.
  - Sets `err_o` and is otherwise ignored: no state change, run count unchanged, statistics unchanged.
- **Idle cycles:** cycles with `in_valid`=0 change nothing; pulses deassert.
- **FSM states:** INIT, LOW, HIGH. There is one run counter, width `$clog2(DEBOUNCE+1)`.
- **INIT:**
  - First well-formed `gt` → HIGH; first `lt` → LOW. Neither transition pulses `rise_o`/`fall_o`.
  - `eq` stays in INIT.
  - Run counter is held at 0.
- **LOW:**
  - `gt` increments the run counter.
  - `lt` clears the run counter.
  - `eq` holds the run counter (neutral).
  - When a `gt` brings the count to `DEBOUNCE`: go to HIGH, clear the counter, assert `rise_o`.
- **HIGH:** mirror image of LOW. `lt` counts, `gt` clears, `eq` holds. Reaching `DEBOUNCE` goes to LOW and asserts `fall_o`.
- **DEBOUNCE=1:** a single opposing sample switches the level.
- **Statistics:** each well-formed sample increments its verdict counter by 1, saturating at 2^CNT_W−1. No wrap.
- **Reset:**
  - `rst`=1 forces INIT, run counter 0, `rise_o`/`fall_o`/`err_o`=0, all statistics 0.
  - `rst` has priority over a simultaneous `in_valid`. That sample is discarded.
  - Reset mid-run discards any partial debounce count.

## Timing
- All outputs are registered.
- A sample presented in cycle N is reflected in `level_o`, pulses, `err_o` and counters in cycle N+1.
- `rise_o`/`fall_o` are high for exactly the one cycle following the qualifying sample. Back-to-back transitions cannot occur closer than `DEBOUNCE` samples apart.
- `err_o` rises in the cycle after the malformed sample and stays high until `rst`.
- There is no backpressure: the block accepts a sample every cycle.
- Reset values:
  - `level_o`=0 (INIT).
  - `rise_o`=0, `fall_o`=0, `err_o`=0.
  - `gt_cnt_o`, `eq_cnt_o`, `lt_cnt_o` all 0.

## Configuration
- `CMP_STATS_EN` defined: the three statistics counters are built as specified.
- `CMP_STATS_EN` undefined:
  - The counters are not instantiated.
  - `gt_cnt_o`, `eq_cnt_o`, `lt_cnt_o` are driven constant 0.
  - The FSM, pulses and `err_o` behave identically.

## Structure
- Shared package `cmp_pkg` holds:
  - The `level_t` enum: INIT=2'd0, LOW=2'd1, HIGH=2'd2.
  - A `verdict_t` struct {gt, eq, lt}.
  - A `verdict_ok()` function for the exactly-one-hot check.
- Sub-module `cmp_sat_counter` (parameter W; ports clk, rst, inc, cnt_o) is instantiated three times under `CMP_STATS_EN`.
- The FSM and run counter stay in the top module.

## Test plan
- **Reset sweep:** reset, then idle 3 cycles → `level_o`=0, all outputs 0.
- **Debounce up (DEBOUNCE=4):**
  - Stimulus: `lt`, then `gt`,`gt`,`eq`,`gt`,`gt`.
  - Required: `level_o`=1 after the first sample; `rise_o` high only in the cycle after the 4th `gt`; `level_o`=2 from then on.
- **Interrupted run:** in HIGH, send `lt`,`lt`,`lt`,`gt`,`lt`,`lt`,`lt` → no `fall_o`; in HIGH, send 4 more `lt` → `fall_o` pulses once.
- **Malformed verdicts:** `gt`=`lt`=1, then all-zero with `in_valid`=1 → `err_o`=1 sticky; `level_o` and counters unchanged.
- **Saturation (CNT_W=2):** 5 valid `eq` samples → `eq_cnt_o`=3. Without `CMP_STATS_EN`, all counts stay 0.
- **Reset mid-run:** assert `rst` with `in_valid`=1 and `gt`=1 after 3 `gt` in LOW → `level_o`=0, counts 0, no `rise_o`.
